// File: rtl/csregfile_mp_pkg.sv
// Shared definitions for the multi-port GPR/CSR register file:
// CSR addresses, CSR op encodings and default data width.
package csregfile_mp_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with per-half software overwrite; a write in a cycle
// replaces that half and suppresses the increment for that cycle.
module csr_counter64 #(
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] inc,
    input  logic          we_lo,
    input  logic          we_hi,
    input  logic [31:0]   wdata,
    output logic [63:0]   count_o
);

    logic [63:0] count_r;

    // Counter state: software write takes precedence over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 64'h0;
        end else if (we_lo) begin
            count_r <= {count_r[63:32], wdata};
        end else if (we_hi) begin
            count_r <= {wdata, count_r[31:0]};
        end else begin
            count_r <= count_r + 64'(inc);
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/csregfile_mp.sv
// Multi-port integer register file with write-to-read bypass, plus the
// machine-mode CSR bank (atomic RW/RS/RC) and mcycle/minstret counters.
module csregfile_mp
    import csregfile_mp_pkg::*;
#(
    parameter int               XLEN       = XLEN_DEF,
    parameter int               REG_NUM    = 32,
    parameter int               NUM_RPORTS = 2,
    parameter int               NUM_WPORTS = 2,
    parameter logic [XLEN-1:0]  VENDOR_ID  = 32'h0,
    parameter logic [XLEN-1:0]  MTVEC_RST  = 32'h0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_RPORTS*$clog2(REG_NUM)-1:0]  rs_raddr,
    output logic [NUM_RPORTS*XLEN-1:0]             rs_rdata_o,
    input  logic [NUM_WPORTS-1:0]                  rd_we,
    input  logic [NUM_WPORTS*$clog2(REG_NUM)-1:0]  rd_waddr,
    input  logic [NUM_WPORTS*XLEN-1:0]             rd_wdata,
    input  logic                                   csr_en,
    input  logic [1:0]                             csr_op,
    input  logic [11:0]                            csr_addr,
    input  logic [XLEN-1:0]                        csr_wdata,
    output logic [XLEN-1:0]                        csr_rdata_o,
    output logic                                   csr_illegal_o,
    input  logic [$clog2(NUM_WPORTS+1)-1:0]        retire_cnt
);

    localparam int AW  = $clog2(REG_NUM);
    localparam int RCW = $clog2(NUM_WPORTS+1);

    logic [XLEN-1:0] gpr_r [REG_NUM];
    logic [NUM_RPORTS*XLEN-1:0] rs_rdata_s;

    // GPR storage; ascending port loop lets the highest-index enabled port win
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) gpr_r[i] <= '0;
        end else begin
            for (int w = 0; w < NUM_WPORTS; w++) begin
                if (rd_we[w] && (rd_waddr[w*AW +: AW] != '0))
                    gpr_r[rd_waddr[w*AW +: AW]] <= rd_wdata[w*XLEN +: XLEN];
            end
        end
    end

    // Read ports with same-cycle bypass, same port priority as the write side
    always_comb begin
        rs_rdata_s = '0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            if (rs_raddr[p*AW +: AW] != '0) begin
                rs_rdata_s[p*XLEN +: XLEN] = gpr_r[rs_raddr[p*AW +: AW]];
            end else begin
                rs_rdata_s[p*XLEN +: XLEN] = '0;
            end
            for (int w = 0; w < NUM_WPORTS; w++) begin
                rs_rdata_s[p*XLEN +: XLEN] =
                    (rd_we[w] && (rd_waddr[w*AW +: AW] == rs_raddr[p*AW +: AW]) &&
                     (rs_raddr[p*AW +: AW] != '0)) ? rd_wdata[w*XLEN +: XLEN]
                                                   : rs_rdata_s[p*XLEN +: XLEN];
            end
        end
    end

    assign rs_rdata_o = rs_rdata_s;

    logic [XLEN-1:0] mstatus_r, mtvec_r, mepc_r, mcause_r, mscratch_r;
    logic [63:0]     mcycle_s, minstret_s;
    logic [XLEN-1:0] csr_old_s, csr_new_s;
    logic            csr_impl_s, csr_ro_s, csr_wr_req_s, csr_illegal_s, csr_do_wr_s;
    csr_op_e         csr_op_s;

    assign csr_op_s = csr_op_e'(csr_op);

    // CSR address decode and pre-op value
    always_comb begin
        csr_impl_s = 1'b1;
        csr_ro_s   = 1'b0;
        csr_old_s  = '0;
        case (csr_addr)
            CSR_MSTATUS:   csr_old_s = mstatus_r;
            CSR_MTVEC:     csr_old_s = mtvec_r;
            CSR_MSCRATCH:  csr_old_s = mscratch_r;
            CSR_MEPC:      csr_old_s = mepc_r;
            CSR_MCAUSE:    csr_old_s = mcause_r;
            CSR_MCYCLE:    csr_old_s = XLEN'(mcycle_s[31:0]);
            CSR_MCYCLEH:   csr_old_s = XLEN'(mcycle_s[63:32]);
            CSR_MINSTRET:  csr_old_s = XLEN'(minstret_s[31:0]);
            CSR_MINSTRETH: csr_old_s = XLEN'(minstret_s[63:32]);
            CSR_MVENDORID: begin
                csr_old_s = VENDOR_ID;
                csr_ro_s  = 1'b1;
            end
            default:       csr_impl_s = 1'b0;
        endcase
    end

    // Op evaluation; RS/RC with a zero operand is a pure read and never illegal on RO
    always_comb begin
        csr_new_s = csr_old_s;
        case (csr_op_s)
            CSR_OP_RW: csr_new_s = csr_wdata;
            CSR_OP_RS: csr_new_s = csr_old_s | csr_wdata;
            CSR_OP_RC: csr_new_s = csr_old_s & ~csr_wdata;
            default:   csr_new_s = csr_old_s;
        endcase
        csr_wr_req_s  = csr_en && ((csr_op_s == CSR_OP_RW) ||
                        (((csr_op_s == CSR_OP_RS) || (csr_op_s == CSR_OP_RC)) &&
                         (csr_wdata != '0)));
        csr_illegal_s = csr_en && (!csr_impl_s || (csr_ro_s && csr_wr_req_s));
        csr_do_wr_s   = csr_wr_req_s && !csr_illegal_s;
    end

    assign csr_rdata_o   = csr_old_s;
    assign csr_illegal_o = csr_illegal_s;

    // Plain machine-mode CSR registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_r  <= '0;
            mtvec_r    <= MTVEC_RST;
            mepc_r     <= '0;
            mcause_r   <= '0;
            mscratch_r <= '0;
        end else if (csr_do_wr_s) begin
            case (csr_addr)
                CSR_MSTATUS:  mstatus_r  <= csr_new_s;
                CSR_MTVEC:    mtvec_r    <= csr_new_s;
                CSR_MEPC:     mepc_r     <= csr_new_s;
                CSR_MCAUSE:   mcause_r   <= csr_new_s;
                CSR_MSCRATCH: mscratch_r <= csr_new_s;
                default:      mstatus_r  <= mstatus_r;
            endcase
        end
    end

    csr_counter64 #(.IW(1)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc     (1'b1),
        .we_lo   (csr_do_wr_s && (csr_addr == CSR_MCYCLE)),
        .we_hi   (csr_do_wr_s && (csr_addr == CSR_MCYCLEH)),
        .wdata   (32'(csr_new_s)),
        .count_o (mcycle_s)
    );

    csr_counter64 #(.IW(RCW)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc     (retire_cnt),
        .we_lo   (csr_do_wr_s && (csr_addr == CSR_MINSTRET)),
        .we_hi   (csr_do_wr_s && (csr_addr == CSR_MINSTRETH)),
        .wdata   (32'(csr_new_s)),
        .count_o (minstret_s)
    );

endmodule

// File: tb/tb_csregfile_mp.sv
// Directed self-checking bench for csregfile_mp: GPR priority/bypass,
// CSR RW/RS/RC, counter carry and overwrite, illegal access, mid-run reset.
module tb_csregfile_mp;
    import csregfile_mp_pkg::*;

    logic        clk;
    logic        rst;
    logic [9:0]  rs_raddr;
    logic [63:0] rs_rdata_o;
    logic [1:0]  rd_we;
    logic [9:0]  rd_waddr;
    logic [63:0] rd_wdata;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic [1:0]  retire_cnt;

    int checks   = 0;
    int failures = 0;

    csregfile_mp #(
        .XLEN(32), .REG_NUM(32), .NUM_RPORTS(2), .NUM_WPORTS(2),
        .VENDOR_ID(32'hCAFE_0001), .MTVEC_RST(32'h0000_0100)
    ) dut (
        .clk(clk), .rst(rst), .rs_raddr(rs_raddr), .rs_rdata_o(rs_rdata_o),
        .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
        .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata_o(csr_rdata_o),
        .csr_illegal_o(csr_illegal_o), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next posedge and return strobes to idle
    task automatic cyc();
        @(posedge clk);
        #1;
        rd_we     = 2'b00;
        csr_en    = 1'b0;
        csr_op    = 2'b00;
        csr_wdata = 32'h0;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_en    = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
    endtask

    initial begin
        rst = 1'b1; rs_raddr = 10'h0; rd_we = 2'b00; rd_waddr = 10'h0; rd_wdata = 64'h0;
        csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0; retire_cnt = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rs_raddr = {5'd31, 5'd1};
        csr(2'b00, CSR_MTVEC, 32'h0);
        @(negedge clk);
        chk("rst_rs0", rs_rdata_o[31:0], 32'h0);
        chk("rst_rs1", rs_rdata_o[63:32], 32'h0);
        chk("rst_mtvec", csr_rdata_o, 32'h0000_0100);
        chk("rst_illegal", {31'h0, csr_illegal_o}, 32'h0);

        cyc(); rst = 1'b0; csr(2'b00, CSR_MCYCLE, 32'h0);
        @(negedge clk); chk("mcycle_first", csr_rdata_o, 32'h0);
        cyc(); csr(2'b00, CSR_MCYCLE, 32'h0);
        @(negedge clk); chk("mcycle_one", csr_rdata_o, 32'h1);
        cyc(); csr(2'b00, CSR_MVENDORID, 32'h0);
        @(negedge clk);
        chk("vendor_rd", csr_rdata_o, 32'hCAFE_0001);
        chk("vendor_rd_legal", {31'h0, csr_illegal_o}, 32'h0);

        // GPR write priority and bypass
        cyc(); rd_we = 2'b11; rd_waddr = {5'd1, 5'd1}; rd_wdata = {32'h0000_ABCD, 32'h0000_1234};
        rs_raddr = {5'd0, 5'd1};
        @(negedge clk); chk("x1_bypass_prio", rs_rdata_o[31:0], 32'h0000_ABCD);
        cyc(); rd_we = 2'b01; rd_waddr = {5'd0, 5'd0}; rd_wdata = {32'h0, 32'h0000_DEAD};
        @(negedge clk);
        chk("x1_stored_prio", rs_rdata_o[31:0], 32'h0000_ABCD);
        chk("x0_write_bypass", rs_rdata_o[63:32], 32'h0);
        cyc(); rd_we = 2'b01; rd_waddr = {5'd0, 5'd4}; rd_wdata = {32'h0, 32'h0000_0004};
        rs_raddr = {5'd0, 5'd4};
        @(negedge clk);
        chk("x4_bypass", rs_rdata_o[31:0], 32'h4);
        chk("x0_stored", rs_rdata_o[63:32], 32'h0);
        cyc(); rd_we = 2'b11; rd_waddr = {5'd6, 5'd5}; rd_wdata = {32'h66, 32'h55};
        rs_raddr = {5'd6, 5'd5};
        @(negedge clk);
        chk("x5_bypass_p0", rs_rdata_o[31:0], 32'h55);
        chk("x6_bypass_p1", rs_rdata_o[63:32], 32'h66);
        cyc(); rs_raddr = {5'd6, 5'd4};
        @(negedge clk);
        chk("x4_stored", rs_rdata_o[31:0], 32'h4);
        chk("x6_stored", rs_rdata_o[63:32], 32'h66);

        // mscratch read-modify-write sequence
        cyc(); csr(2'b01, CSR_MSCRATCH, 32'hF0);
        @(negedge clk);
        chk("mscratch_rw_old", csr_rdata_o, 32'h0);
        chk("mscratch_legal", {31'h0, csr_illegal_o}, 32'h0);
        cyc(); csr(2'b10, CSR_MSCRATCH, 32'h0F);
        @(negedge clk); chk("mscratch_rs_old", csr_rdata_o, 32'hF0);
        cyc(); csr(2'b11, CSR_MSCRATCH, 32'h3C);
        @(negedge clk); chk("mscratch_rc_old", csr_rdata_o, 32'hFF);
        cyc(); csr(2'b00, CSR_MSCRATCH, 32'h0);
        @(negedge clk); chk("mscratch_final", csr_rdata_o, 32'hC3);

        // illegal accesses
        cyc(); csr(2'b01, CSR_MVENDORID, 32'h1234);
        @(negedge clk);
        chk("vendor_rw_illegal", {31'h0, csr_illegal_o}, 32'h1);
        chk("vendor_rw_rdata", csr_rdata_o, 32'hCAFE_0001);
        cyc(); csr(2'b00, 12'h7C0, 32'h0);
        @(negedge clk);
        chk("unimpl_illegal", {31'h0, csr_illegal_o}, 32'h1);
        chk("unimpl_rdata", csr_rdata_o, 32'h0);
        cyc(); csr_addr = 12'h7C0;
        @(negedge clk); chk("unimpl_no_en", {31'h0, csr_illegal_o}, 32'h0);
        cyc(); csr(2'b01, 12'h7C0, 32'h5A);
        @(negedge clk); chk("unimpl_rw_illegal", {31'h0, csr_illegal_o}, 32'h1);
        cyc(); csr(2'b00, CSR_MSCRATCH, 32'h0);
        @(negedge clk); chk("mscratch_after_illegal", csr_rdata_o, 32'hC3);

        // mcycle overwrite and carry
        cyc(); csr(2'b01, CSR_MCYCLE, 32'hFFFF_FFFF);
        cyc(); csr(2'b01, CSR_MCYCLEH, 32'h0);
        cyc(); csr(2'b00, CSR_MCYCLE, 32'h0);
        @(negedge clk); chk("mcycle_held", csr_rdata_o, 32'hFFFF_FFFF);
        cyc(); csr(2'b00, CSR_MCYCLEH, 32'h0);
        @(negedge clk); chk("mcycleh_carry", csr_rdata_o, 32'h1);
        cyc(); csr(2'b00, CSR_MCYCLE, 32'h0);
        @(negedge clk); chk("mcycle_after_carry", csr_rdata_o, 32'h1);

        // minstret by retire_cnt
        cyc(); retire_cnt = 2'd2; csr(2'b00, CSR_MINSTRET, 32'h0);
        @(negedge clk); chk("minstret_start", csr_rdata_o, 32'h0);
        cyc(); cyc();
        cyc(); retire_cnt = 2'd0; csr(2'b00, CSR_MINSTRET, 32'h0);
        @(negedge clk); chk("minstret_six", csr_rdata_o, 32'h6);
        cyc(); csr(2'b00, CSR_MINSTRETH, 32'h0);
        @(negedge clk); chk("minstreth_zero", csr_rdata_o, 32'h0);

        cyc(); csr(2'b01, CSR_MTVEC, 32'h200);
        cyc(); csr(2'b01, CSR_MSTATUS, 32'h88);
        cyc(); csr(2'b00, CSR_MTVEC, 32'h0);
        @(negedge clk); chk("mtvec_written", csr_rdata_o, 32'h200);
        cyc(); csr(2'b00, CSR_MSTATUS, 32'h0);
        @(negedge clk); chk("mstatus_written", csr_rdata_o, 32'h88);

        // mid-run reset
        cyc(); rst = 1'b1; rs_raddr = {5'd4, 5'd1}; csr(2'b00, CSR_MSTATUS, 32'h0);
        @(negedge clk);
        chk("mrst_mstatus", csr_rdata_o, 32'h0);
        chk("mrst_x1", rs_rdata_o[31:0], 32'h0);
        chk("mrst_x4", rs_rdata_o[63:32], 32'h0);
        cyc(); csr(2'b00, CSR_MTVEC, 32'h0);
        @(negedge clk); chk("mrst_mtvec", csr_rdata_o, 32'h0000_0100);
        cyc(); csr(2'b00, CSR_MCYCLEH, 32'h0);
        @(negedge clk); chk("mrst_mcycleh", csr_rdata_o, 32'h0);
        cyc(); csr(2'b00, CSR_MINSTRET, 32'h0);
        @(negedge clk); chk("mrst_minstret", csr_rdata_o, 32'h0);
        cyc(); csr(2'b00, CSR_MSCRATCH, 32'h0);
        @(negedge clk); chk("mrst_mscratch", csr_rdata_o, 32'h0);
        cyc(); rst = 1'b0; csr(2'b00, CSR_MCYCLE, 32'h0);
        @(negedge clk); chk("post_rst_mcycle0", csr_rdata_o, 32'h0);
        cyc(); csr(2'b00, CSR_MCYCLE, 32'h0);
        @(negedge clk);
        chk("post_rst_mcycle1", csr_rdata_o, 32'h1);
        chk("post_rst_x1", rs_rdata_o[31:0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csregfile_mp.md
# csregfile_mp

Parametrised multi-port successor to the core's combined GPR/CSR register file. Holds the integer register bank with NUM_RPORTS combinational read ports and NUM_WPORTS write ports, plus a machine-mode CSR bank with atomic read-modify-write ops and 64-bit mcycle/minstret counters. Sits between decode (reads), writeback (writes) and the CSR execute unit, with write-to-read bypass so that same-cycle hazards need no stall.

## Interface
- XLEN, 32: data width.
- REG_NUM, 32: GPR count; address width AW = clog2(REG_NUM).
- NUM_RPORTS, 2: GPR read ports.
- NUM_WPORTS, 2: GPR write ports; port index = priority, highest wins.
- VENDOR_ID, 32'h0: mvendorid constant.
- MTVEC_RST, 32'h0: mtvec reset value.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- rs_raddr  in  NUM_RPORTS*AW  packed read addresses, port p at [p*AW +: AW].
- rs_rdata_o  out  NUM_RPORTS*XLEN  read data.
- rd_we  in  NUM_WPORTS  per-port write enable.
- rd_waddr  in  NUM_WPORTS*AW  write addresses.
- rd_wdata  in  NUM_WPORTS*XLEN  write data.
- csr_en  in  1  CSR access valid this cycle.
- csr_op  in  2  00 none/read, 01 RW, 10 RS (set bits), 11 RC (clear bits).
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  operand.
- csr_rdata_o  out  XLEN  pre-op value of the addressed CSR.
- csr_illegal_o  out  1  unimplemented address, or write op to read-only CSR.
- retire_cnt  in  clog2(NUM_WPORTS+1)  instructions retired this cycle.

## Operation
- GPR x0 reads 0 always; writes to x0 ignored.
- Multiple write ports to the same address in one cycle: highest-index enabled port wins.
- Read bypass: if any enabled write port targets the read address (non-zero), rs_rdata_o returns that port's wdata (same priority) instead of stored value.
- Implemented CSRs: mstatus, mtvec, mepc, mcause, mscratch (RW); mcycle, mcycleh, minstret, minstreth (RW); mvendorid (RO, = VENDOR_ID).
- CSR write value: RW = wdata; RS = old | wdata; RC = old & ~wdata. RS/RC with wdata 0 perform no write (no side effect).
- csr_illegal_o combinational, only meaningful while csr_en=1, else 0; illegal access causes no state change; csr_rdata_o reads 0 for unimplemented addresses.
- mcycle (64 bits) increments by 1 every cycle out of reset; minstret (64 bits) increments by retire_cnt. Carry from low into high half in the same cycle; wrap 2^64-1 -> 0.
- Software write to either half of a counter in a cycle replaces that half with the written value and suppresses that counter's increment for that cycle (the other half holds).

## Timing
- Reset: all GPRs 0, mstatus/mepc/mcause/mscratch 0, mtvec MTVEC_RST, counters 0; hence all read outputs 0 during reset (mvendorid excepted).
- Reads combinational, zero latency; writes visible in storage from the next cycle, via bypass in the same cycle.
- CSR read returns pre-op value in the access cycle; new value visible next cycle. mcycle read returns value before this cycle's increment.
- rst asserted mid-operation clears state immediately; the first posedge after deassertion increments mcycle to 1.

## Structure
- Shared package: CSR address constants, csr_op encodings, XLEN default.
- Sub-module csr_counter64: 64-bit counter with increment amount, per-half write enables and write data; instantiated for mcycle and minstret.

## Test plan
- Reset then write x1=0x1234 on port 0 and x1=0xABCD on port 1 in the same cycle -> next cycle x1 reads 0xABCD; write to x0 -> reads 0.
- Write x4=0x4 while rs0 reads x4 -> rs_rdata_o[0] = 0x4 in the same cycle.
- mscratch RW 0xF0, then RS 0x0F, then RC 0x3C -> csr_rdata_o returns 0, 0xF0, 0xFF; final value 0xC3.
- Write mcycle=0xFFFFFFFF, mcycleh=0 -> after two cycles mcycleh=1, mcycle=0x1; retire_cnt=2 for 3 cycles -> minstret=6.
- RW to mvendorid or access to 0x7C0 -> csr_illegal_o=1, no state change.
- Assert rst mid-sequence -> all GPRs, counters, mstatus read 0, mtvec reads MTVEC_RST.
